// File: rtl/dot_tracker_if.sv
// Bundle between dot_tracker and its surroundings: frame strobe, Pac-Man position,
// wall query port and the pellet map, score and status outputs.
interface dot_tracker_if;
    logic                 frame_clk;
    logic                 restart;
    logic [9:0]           pacman_x;
    logic [9:0]           pacman_y;
    logic [9:0]           wall_qx;
    logic [9:0]           wall_qy;
    logic                 wall_hit;
    logic [41:0][41:0]    dots;
    logic [15:0]          score;
    logic [10:0]          dots_left;
    logic                 busy;
    logic                 level_clear;
    logic                 reversal;

    modport master (
        output frame_clk, restart, pacman_x, pacman_y, wall_hit,
        input  wall_qx, wall_qy, dots, score, dots_left, busy, level_clear, reversal
    );

    modport slave (
        input  frame_clk, restart, pacman_x, pacman_y, wall_hit,
        output wall_qx, wall_qy, dots, score, dots_left, busy, level_clear, reversal
    );
endinterface

// File: rtl/dot_tracker.sv
// 42x42 pellet grid owner: scans walls after reset, eats the pellet under Pac-Man each frame.
// Optional power pellets and ghost reversal timer: define DOT_TRACKER_POWER_PELLET_EN.
module dot_tracker #(
    parameter int DOT_POINTS = 10
`ifdef DOT_TRACKER_POWER_PELLET_EN
    ,
    parameter int PELLET_POINTS   = 50,
    parameter int REVERSAL_FRAMES = 480
`endif
) (
    input  logic         clk,
    input  logic         rst,
    dot_tracker_if.slave bus
);
    // state | meaning
    // INIT  | scanning walls, one cell per clock
    // RUN   | eating pellets on frame strobes
    // DONE  | level cleared, outputs frozen until restart/reset
    localparam int GRID_N    = 42;
    localparam int GRID_ORG  = 56;
    localparam int SCAN_LAST = GRID_N * GRID_N;
    localparam logic [9:0] QORG = 10'(GRID_ORG + 4);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_DONE} state_t;

    state_t            state;
    logic [10:0]       scan_idx;
    logic [5:0]        cx, cy, pcx, pcy;
    logic              frame_clk_q;
    logic [41:0][41:0] dots;
    logic [15:0]       score;
    logic [10:0]       dots_left;
    logic              busy, level_clear;
    logic [9:0]        wall_qx, wall_qy;

    logic              eat_stb, in_x, in_y, eat_go, is_pellet;
    logic [10:0]       px, py, ox, oy;
    logic [5:0]        ecx, ecy;
    logic [15:0]       eat_pts, score_next;
    logic [16:0]       score_sum;

    function automatic logic [9:0] qpix(input logic [5:0] c);
        return QORG + {1'b0, c, 3'b000};
    endfunction

    always_comb begin
        eat_stb    = bus.frame_clk & ~frame_clk_q;
        px         = {1'b0, bus.pacman_x} + 11'd4;
        py         = {1'b0, bus.pacman_y} + 11'd4;
        ox         = px - 11'(GRID_ORG);
        oy         = py - 11'(GRID_ORG);
        in_x       = (px >= 11'(GRID_ORG)) && (ox < 11'(GRID_N * 8));
        in_y       = (py >= 11'(GRID_ORG)) && (oy < 11'(GRID_N * 8));
        ecx        = ox[8:3];
        ecy        = oy[8:3];
        eat_go     = (state == S_RUN) && eat_stb && in_x && in_y && dots[ecx][ecy]
                     && (dots_left != 11'd0);
        is_pellet  = 1'b0;
        eat_pts    = 16'(DOT_POINTS);
`ifdef DOT_TRACKER_POWER_PELLET_EN
        is_pellet  = ((ecx == 6'd1) || (ecx == 6'd40)) && ((ecy == 6'd1) || (ecy == 6'd40));
        if (is_pellet)
            eat_pts = 16'(PELLET_POINTS);
`endif
        score_sum  = {1'b0, score} + {1'b0, eat_pts};
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_clk_q <= 1'b0;
        else
            frame_clk_q <= bus.frame_clk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT;
            scan_idx    <= '0;
            cx          <= '0;
            cy          <= '0;
            pcx         <= '0;
            pcy         <= '0;
            dots        <= '1;
            score       <= '0;
            dots_left   <= '0;
            busy        <= 1'b1;
            level_clear <= 1'b0;
            wall_qx     <= QORG;
            wall_qy     <= QORG;
        end else begin
            level_clear <= 1'b0;
            if (bus.restart) begin
                state     <= S_INIT;
                scan_idx  <= '0;
                cx        <= '0;
                cy        <= '0;
                pcx       <= '0;
                pcy       <= '0;
                dots      <= '1;
                score     <= '0;
                dots_left <= '0;
                busy      <= 1'b1;
                wall_qx   <= QORG;
                wall_qy   <= QORG;
            end else begin
                case (state)
                    S_INIT: begin
                        // wall_hit answers the query issued one cycle earlier (pcx, pcy)
                        if (scan_idx != 11'd0) begin
                            if (bus.wall_hit)
                                dots[pcx][pcy] <= 1'b0;
                            else
                                dots_left <= dots_left + 11'd1;
                        end
                        if (scan_idx == 11'(SCAN_LAST)) begin
                            busy <= 1'b0;
                            if ((dots_left == 11'd0) && bus.wall_hit) begin
                                state       <= S_DONE;
                                level_clear <= 1'b1;
                            end else begin
                                state <= S_RUN;
                            end
                        end else begin
                            scan_idx <= scan_idx + 11'd1;
                            pcx      <= cx;
                            pcy      <= cy;
                            if (cx == 6'(GRID_N - 1)) begin
                                cx      <= '0;
                                cy      <= cy + 6'd1;
                                wall_qx <= QORG;
                                wall_qy <= qpix(cy + 6'd1);
                            end else begin
                                cx      <= cx + 6'd1;
                                wall_qx <= qpix(cx + 6'd1);
                            end
                        end
                    end
                    S_RUN: begin
                        if (eat_go) begin
                            dots[ecx][ecy] <= 1'b0;
                            dots_left      <= dots_left - 11'd1;
                            score          <= score_next;
                            if (dots_left == 11'd1) begin
                                level_clear <= 1'b1;
                                state       <= S_DONE;
                            end
                        end
                    end
                    S_DONE: ;
                    default: state <= S_INIT;
                endcase
            end
        end
    end

`ifdef DOT_TRACKER_POWER_PELLET_EN
    logic [8:0] rev_cnt;

    // counts frames, not clocks; keeps running in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rev_cnt <= '0;
        else if (bus.restart)
            rev_cnt <= '0;
        else if (eat_stb) begin
            if (eat_go && is_pellet)
                rev_cnt <= 9'(REVERSAL_FRAMES);
            else if (rev_cnt != 9'd0)
                rev_cnt <= rev_cnt - 9'd1;
        end
    end

    assign bus.reversal = (rev_cnt != 9'd0);
`else
    assign bus.reversal = 1'b0;
`endif

    assign bus.wall_qx     = wall_qx;
    assign bus.wall_qy     = wall_qy;
    assign bus.dots        = dots;
    assign bus.score       = score;
    assign bus.dots_left   = dots_left;
    assign bus.busy        = busy;
    assign bus.level_clear = level_clear;
endmodule
